// File: rtl/fetch_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fetch_pkg: shared types and constants for the fetch sequencer.  |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_e;

  localparam int unsigned INST_BYTES          = 4;
  localparam logic [31:0] DEFAULT_TRAP_VECTOR = 32'h0000_0080;

endpackage
`default_nettype wire

// File: rtl/fetch_out_buf.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fetch_out_buf: output register plus one-entry skid, with flush. |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module fetch_out_buf
  import fetch_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        wr_i,
  input  logic [31:0] wr_inst_i,
  input  logic [31:0] wr_pc_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o
);

  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc_q, pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        slot_free;

  always_comb begin
    valid_d      = valid_q;
    inst_d       = inst_q;
    pc_d         = pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;
    slot_free    = !valid_q || ready_i;

    if (flush_i) begin
      valid_d      = 1'b0;
      skid_valid_d = 1'b0;
    end else if (slot_free) begin
      // A parked skid entry always drains ahead of any new write.
      if (skid_valid_q) begin
        valid_d      = 1'b1;
        inst_d       = skid_inst_q;
        pc_d         = skid_pc_q;
        skid_valid_d = 1'b0;
      end else if (wr_i) begin
        valid_d = 1'b1;
        inst_d  = wr_inst_i;
        pc_d    = wr_pc_i;
      end else begin
        valid_d = 1'b0;
      end
    end else if (wr_i) begin
      skid_valid_d = 1'b1;
      skid_inst_d  = wr_inst_i;
      skid_pc_d    = wr_pc_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      inst_q       <= '0;
      pc_q         <= '0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= '0;
      skid_pc_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      inst_q       <= inst_d;
      pc_q         <= pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

  assign valid_o = valid_q;
  assign inst_o  = inst_q;
  assign pc_o    = pc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | fetch_sequencer: PC sequencing and instruction-fetch control.   |
// | Revision: 1.0                                                   |
// +-----------------------------------------------------------------+
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter logic [31:0] TRAP_VECTOR = DEFAULT_TRAP_VECTOR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] pc_cur_i,
  output logic [31:0] pc_next_o,
  output logic        pc_stall_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_data_i,
  output logic        if_valid_o,
  input  logic        if_ready_i,
  output logic [31:0] if_inst_o,
  output logic [31:0] if_pc_o,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        trap_i
);

  fetch_state_e state_q, state_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic         flush;
  logic         slot_free;
  logic         buf_wr;

  always_comb begin
    flush        = trap_i || redirect_i;
    slot_free    = !if_valid_o || if_ready_i;
    state_d      = state_q;
    drain_addr_d = drain_addr_q;
    imem_req_o   = 1'b0;
    imem_addr_o  = '0;
    buf_wr       = 1'b0;

    case (state_q)
      IDLE: begin
        if (slot_free) state_d = REQ;
      end
      REQ: begin
        imem_req_o  = 1'b1;
        imem_addr_o = pc_cur_i;
        if (imem_ack_i) begin
          buf_wr  = 1'b1;
          state_d = slot_free ? REQ : HOLD;
        end
      end
      HOLD: begin
        if (if_ready_i) state_d = IDLE;
      end
      DRAIN: begin
        imem_req_o  = 1'b1;
        imem_addr_o = drain_addr_q;
        if (imem_ack_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An unacked request must still be completed, so it is finished in DRAIN.
    if (flush) begin
      buf_wr = 1'b0;
      case (state_q)
        REQ: begin
          if (imem_ack_i) begin
            state_d = IDLE;
          end else begin
            state_d      = DRAIN;
            drain_addr_d = pc_cur_i;
          end
        end
        DRAIN:   state_d = DRAIN;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    if (trap_i)          pc_next_o = TRAP_VECTOR;
    else if (redirect_i) pc_next_o = redirect_pc_i;
    else                 pc_next_o = pc_cur_i + 32'(INST_BYTES);
  end

  assign pc_stall_o = !(buf_wr || flush);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      drain_addr_q <= drain_addr_d;
    end
  end

  fetch_out_buf u_out_buf (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush),
    .wr_i      (buf_wr),
    .wr_inst_i (imem_data_i),
    .wr_pc_i   (pc_cur_i),
    .ready_i   (if_ready_i),
    .valid_o   (if_valid_o),
    .inst_o    (if_inst_o),
    .pc_o      (if_pc_o)
  );

endmodule
`default_nettype wire
